psum_accumulator: RTL and testbench

- Upstream neighbour of the output scaler.
- Collects signed partial sums from the compute array over a configurable number of passes and adds a per-result bias once.
- Saturates the running sum to accWidth and presents the finished pre-scale value wx on a valid/ready interface.
- wx_o connects directly to the scaler's wx_i; accWidth matches the scaler's inputWidth.

---
 rtl/qr_acc_pkg.sv | 17 +
 rtl/psum_accumulator_if.sv | 30 +++
 rtl/sat_adder.sv | 24 ++
 rtl/psum_accumulator.sv | 83 ++++++++
 tb/tb_psum_accumulator.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/qr_acc_pkg.sv
// qr_acc_pkg: shared accumulator state encoding and signed clamp constants.
//   acc_state_t    : IDLE / ACCUM / HOLD
//   sat_max(width) : largest signed value representable in width bits
//   sat_min(width) : smallest signed value representable in width bits
package qr_acc_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;

    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if: partial-sum input stream, per-result config and wx output stream.
//   psum_i/psum_valid_i/psum_ready_o : signed partial-sum handshake
//   bias_i/num_passes_i              : config sampled on the first beat of a result
//   wx_o/wx_valid_o/wx_ready_i/sat_o : finished result handshake plus saturation flag
//   master: drives the stream and consumes results; slave: the accumulator
interface psum_accumulator_if #(
    parameter int psumWidth   = 16,
    parameter int accWidth    = 20,
    parameter int passCntBits = 8
);
    logic signed [psumWidth-1:0] psum_i;
    logic                        psum_valid_i;
    logic                        psum_ready_o;
    logic signed [accWidth-1:0]  bias_i;
    logic [passCntBits-1:0]      num_passes_i;
    logic signed [accWidth-1:0]  wx_o;
    logic                        wx_valid_o;
    logic                        wx_ready_i;
    logic                        sat_o;

    modport master (
        output psum_i, psum_valid_i, bias_i, num_passes_i, wx_ready_i,
        input  psum_ready_o, wx_o, wx_valid_o, sat_o
    );

    modport slave (
        input  psum_i, psum_valid_i, bias_i, num_passes_i, wx_ready_i,
        output psum_ready_o, wx_o, wx_valid_o, sat_o
    );
endinterface

// File: rtl/sat_adder.sv
// sat_adder: combinational signed add of two width-bit operands with clamping.
//   a, b : signed operands
//   sum  : a+b clamped to the signed width-bit range
//   ovf  : high when the clamp was applied
module sat_adder
    import qr_acc_pkg::*;
#(
    parameter int width = 20
) (
    input  logic signed [width-1:0] a,
    input  logic signed [width-1:0] b,
    output logic signed [width-1:0] sum,
    output logic                    ovf
);
    localparam logic signed [width-1:0] max_v = width'(sat_max(width));
    localparam logic signed [width-1:0] min_v = width'(sat_min(width));

    logic signed [width:0] full;

    assign full = {a[width-1], a} + {b[width-1], b};
    // Top two bits disagree exactly when the true sum left the width-bit range.
    assign ovf  = full[width] != full[width-1];
    assign sum  = ovf ? (full[width] ? min_v : max_v) : full[width-1:0];
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates num_passes signed partial sums plus a bias, saturating per beat.
//   clk    : rising-edge clock
//   nrst   : asynchronous reset, active-high
//   bus    : slave side of psum_accumulator_if (psum stream in, wx stream out)
//   busy_o : high while a result is being accumulated or held
module psum_accumulator
    import qr_acc_pkg::*;
#(
    parameter int psumWidth   = 16,
    parameter int accWidth    = 20,
    parameter int passCntBits = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    psum_accumulator_if.slave    bus,
    output logic                 busy_o
);
    acc_state_t state, state_n;
    logic signed [accWidth-1:0] acc, acc_n, add_a, add_sum, psum_ext;
    logic [passCntBits-1:0]     cnt, cnt_n, target, target_n, cnt_inc, cfg_target;
    logic                       sat, sat_n, add_ovf, beat;

    assign psum_ext   = accWidth'(bus.psum_i);
    assign cnt_inc    = cnt + 1'b1;
    assign cfg_target = (bus.num_passes_i == '0) ? passCntBits'(1) : bus.num_passes_i;

    // A HOLD beat is only accepted alongside the output transfer, so it always starts a new result.
    assign bus.psum_ready_o = (state != HOLD) || bus.wx_ready_i;
    assign beat             = bus.psum_valid_i && bus.psum_ready_o;
    assign add_a            = (state == ACCUM) ? acc : bus.bias_i;

    assign bus.wx_valid_o = state == HOLD;
    assign bus.wx_o       = acc;
    assign bus.sat_o      = (state == HOLD) && sat;
    assign busy_o         = state != IDLE;

    sat_adder #(.width(accWidth)) u_add (
        .a   (add_a),
        .b   (psum_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            target <= passCntBits'(1);
            sat    <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            target <= target_n;
            sat    <= sat_n;
        end
    end

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        target_n = target;
        sat_n    = sat;
        if (state == ACCUM) begin
            if (beat) begin
                acc_n   = add_sum;
                cnt_n   = cnt_inc;
                sat_n   = sat | add_ovf;
                state_n = (cnt_inc == target) ? HOLD : ACCUM;
            end
        end else if (beat) begin
            acc_n    = add_sum;
            cnt_n    = passCntBits'(1);
            target_n = cfg_target;
            sat_n    = add_ovf;
            state_n  = (cfg_target == passCntBits'(1)) ? HOLD : ACCUM;
        end else if (state == HOLD && bus.wx_ready_i) begin
            state_n = IDLE;
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed self-checking bench for psum_accumulator.
module tb_psum_accumulator;
    localparam int PW = 16;
    localparam int AW = 20;
    localparam int CB = 8;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    psum_accumulator_if #(.psumWidth(PW), .accWidth(AW), .passCntBits(CB)) bus ();

    psum_accumulator #(.psumWidth(PW), .accWidth(AW), .passCntBits(CB)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .bus    (bus),
        .busy_o (busy)
    );

    typedef struct {
        int bias;
        int psum;
        int wx;
        bit sat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int bias, input int psum, input int np);
        bus.psum_valid_i = v;
        bus.bias_i       = AW'(bias);
        bus.psum_i       = PW'(psum);
        bus.num_passes_i = CB'(np);
    endtask

    initial begin
        vecs[0] = '{100, -30, 70, 1'b0};
        vecs[1] = '{0, 0, 0, 1'b0};
        vecs[2] = '{524287, 1, 524287, 1'b1};
        vecs[3] = '{-524288, -1, -524288, 1'b1};
        vecs[4] = '{-100, 32767, 32667, 1'b0};
        vecs[5] = '{524287, -32768, 491519, 1'b0};

        drive(0, 0, 0, 1);
        bus.wx_ready_i = 1'b1;
        #1;
        check("rst_ready", bus.psum_ready_o, 1);
        check("rst_valid", bus.wx_valid_o, 0);
        check("rst_wx", bus.wx_o, 0);
        check("rst_sat", bus.sat_o, 0);
        check("rst_busy", busy, 0);
        tick();
        nrst = 1'b0;
        tick();

        // single-pass table
        foreach (vecs[i]) begin
            drive(1, vecs[i].bias, vecs[i].psum, 1);
            check("tbl_ready", bus.psum_ready_o, 1);
            tick();
            bus.psum_valid_i = 1'b0;
            check("tbl_valid", bus.wx_valid_o, 1);
            check("tbl_wx", bus.wx_o, vecs[i].wx);
            check("tbl_sat", bus.sat_o, vecs[i].sat);
            check("tbl_busy", busy, 1);
            tick();
            check("tbl_idle_busy", busy, 0);
            check("tbl_idle_valid", bus.wx_valid_o, 0);
        end

        // four passes with a bubble; mid-result config changes are ignored
        drive(1, -5, 10, 4);
        tick();
        drive(1, 999, 20, 1);
        tick();
        bus.psum_valid_i = 1'b0;
        tick();
        check("p4_bubble_valid", bus.wx_valid_o, 0);
        check("p4_bubble_busy", busy, 1);
        drive(1, 999, 30, 1);
        tick();
        check("p4_b3_valid", bus.wx_valid_o, 0);
        bus.psum_i = PW'(40);
        tick();
        bus.psum_valid_i = 1'b0;
        check("p4_valid", bus.wx_valid_o, 1);
        check("p4_wx", bus.wx_o, 95);
        check("p4_sat", bus.sat_o, 0);
        tick();
        check("p4_idle", busy, 0);

        // positive saturation
        drive(1, 524000, 1000, 2);
        tick();
        tick();
        bus.psum_valid_i = 1'b0;
        check("psat_wx", bus.wx_o, 524287);
        check("psat_sat", bus.sat_o, 1);
        tick();
        // negative saturation
        drive(1, -524000, -1000, 2);
        tick();
        tick();
        bus.psum_valid_i = 1'b0;
        check("nsat_wx", bus.wx_o, -524288);
        check("nsat_sat", bus.sat_o, 1);
        tick();
        // clamp then opposite-sign beat continues from clamped value
        drive(1, 524000, 1000, 3);
        tick();
        bus.psum_i = PW'(-1000);
        tick();
        bus.psum_i = PW'(0);
        tick();
        bus.psum_valid_i = 1'b0;
        check("unsat_wx", bus.wx_o, 523287);
        check("unsat_sat", bus.sat_o, 1);
        tick();
        check("unsat_idle", busy, 0);

        // backpressure
        bus.wx_ready_i = 1'b0;
        drive(1, 0, 5, 1);
        tick();
        bus.psum_i = PW'(6);
        for (int k = 0; k < 5; k++) begin
            check("bp_ready", bus.psum_ready_o, 0);
            check("bp_wx", bus.wx_o, 5);
            check("bp_valid", bus.wx_valid_o, 1);
            tick();
        end
        bus.wx_ready_i = 1'b1;
        #1;
        check("bp_release_ready", bus.psum_ready_o, 1);
        tick();
        bus.psum_valid_i = 1'b0;
        check("bp_next_valid", bus.wx_valid_o, 1);
        check("bp_next_wx", bus.wx_o, 6);
        tick();
        check("bp_idle", busy, 0);

        // back-to-back single pass
        drive(1, 0, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            bus.psum_i = PW'(k);
            tick();
            check("b2b_valid", bus.wx_valid_o, 1);
            check("b2b_wx", bus.wx_o, k);
        end
        bus.psum_valid_i = 1'b0;
        tick();
        check("b2b_idle", bus.wx_valid_o, 0);

        // reset mid-result
        drive(1, 0, 10, 3);
        tick();
        tick();
        bus.psum_valid_i = 1'b0;
        check("mr_busy_pre", busy, 1);
        nrst = 1'b1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_valid", bus.wx_valid_o, 0);
        check("mr_wx", bus.wx_o, 0);
        tick();
        nrst = 1'b0;
        tick();
        check("mr_nooutput", bus.wx_valid_o, 0);
        drive(1, 7, 1, 0);
        tick();
        bus.psum_valid_i = 1'b0;
        check("mr_np0_valid", bus.wx_valid_o, 1);
        check("mr_np0_wx", bus.wx_o, 8);
        tick();
        check("mr_np0_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
